// File: rtl/decode_stage_q.sv
// rtl/decode_stage_q.sv - queued MIPS decode stage: instruction FIFO, head decode, registered valid/ready output
module decode_stage_q #(
  parameter int QUEUE_DEPTH = 4,
  parameter int TRAP_HOLD   = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_instr,
  input  logic [31:0]                        in_pc,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [41:0]                        out_packed,
  output logic [31:0]                        out_pc,
  output logic                               out_illegal,
  output logic                               trap_pending,
  input  logic                               trap_clear,
  output logic [$clog2(QUEUE_DEPTH):0]       occupancy
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, TRAP} state_t;

  state_t state_q, state_d;

  // shamt (instr[10:6]) is never decoded, so only the remaining 27 bits are queued
  logic [26:0]   instr_mem_q [QUEUE_DEPTH];
  logic [31:0]   pc_mem_q    [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic          out_valid_q, out_illegal_q;
  logic [41:0]   out_packed_q;
  logic [31:0]   out_pc_q;

  logic          push, load;
  logic          unused_shamt;

  assign unused_shamt = ^in_instr[10:6];

  assign in_ready = (count_q != CW'(QUEUE_DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign load     = (count_q != '0) && (state_q == RUN) && (!out_valid_q || out_ready) && !flush;
  assign count_d  = count_q + CW'(push) - CW'(load);

  // Head decode
  logic [26:0] head;
  logic [5:0]  opc, fun;
  logic [4:0]  rs, rt, rd;
  logic        is_i, is_j, is_r, r_fun_ok, dec_illegal, i_bit, gp_we_raw;
  logic [3:0]  af, bf;
  logic [4:0]  cad;
  logic [2:0]  shift_type, gp_mux_sel;
  logic [1:0]  pc_mux_select;
  logic [41:0] dec_word;

  always_comb begin
    head = instr_mem_q[rd_ptr_q];
    opc  = head[26:21];
    rs   = head[20:16];
    rt   = head[15:11];
    rd   = head[10:6];
    fun  = head[5:0];

    is_i = (opc == 6'b100011) || (opc == 6'b101011) || (opc[5:3] == 3'b001) ||
           (opc[5:1] == 5'b00010) || (opc == 6'b000001 && rt[4:1] == 4'b0000) ||
           (opc[5:1] == 5'b00011 && rt == 5'b00000);
    is_j = (opc[5:1] == 5'b00001);
    r_fun_ok = (fun[5:3] == 3'b100) || (fun == 6'b000010) || (fun[5:1] == 5'b10101) ||
               (fun == 6'b001000) || (fun == 6'b001010) || (fun == 6'b001100);
    is_r = (opc == 6'b000000 && r_fun_ok) ||
           (opc == 6'b010000 && ((rs == 5'b10000 && fun == 6'b011000) ||
                                 rs == 5'b00100 || rs == 5'b00000));
    dec_illegal = !(is_i || is_j || is_r);
    i_bit = !is_r;

    af  = i_bit ? {~opc[2] & opc[1], opc[2:0]} : fun[3:0];
    cad = (opc == 6'b000011 || (opc == 6'b000000 && fun == 6'b001001)) ? 5'd31 :
          (i_bit ? rt : rd);
    gp_we_raw = (opc[5:3] == 3'b001) || (opc == 6'b100011) || (opc == 6'b000011) ||
                (opc == 6'b000000 && fun != 6'b001000);
    bf = {opc[2:0], rt[0]};
    shift_type = {i_bit, (af == 4'd0) ? 2'b00 : (af == 4'd2) ? 2'b01 : 2'b10};

    pc_mux_select = 2'b11;
    if (opc == 6'b000000 && (fun == 6'b001000 || fun == 6'b001001)) pc_mux_select = 2'b00;
    else if (opc[5:2] == 4'b0001 || opc == 6'b000001)                pc_mux_select = 2'b01;
    else if (is_j)                                                   pc_mux_select = 2'b10;

    gp_mux_sel = 3'b011;
    if (is_r) begin
      if (fun == 6'b001001)                     gp_mux_sel = 3'b011;
      else if (fun[5:1] == 5'b00001)            gp_mux_sel = 3'b010;
      else if (opc == 6'b010000 && rs == 5'd0)  gp_mux_sel = 3'b100;
      else                                      gp_mux_sel = 3'b000;
    end else if (is_i) begin
      if (opc == 6'b100011)                     gp_mux_sel = 3'b001;
      else if (opc[5:3] == 3'b001)              gp_mux_sel = 3'b000;
    end

    // Writes of any kind are suppressed for undefined words
    dec_word = {af, i_bit, i_bit, shift_type, cad, gp_we_raw && !dec_illegal, gp_mux_sel,
                bf, pc_mux_select, rs != 5'd0,
                (opc == 6'b101011) && !dec_illegal, (opc == 6'b100011) && !dec_illegal,
                rs, rt, rd};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= {in_instr[31:11], in_instr[5:0]};
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (load) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q   <= 1'b0;
      out_packed_q  <= '0;
      out_pc_q      <= '0;
      out_illegal_q <= 1'b0;
    end else if (flush) begin
      out_valid_q   <= 1'b0;
      out_illegal_q <= 1'b0;
    end else if (load) begin
      out_valid_q   <= 1'b1;
      out_packed_q  <= dec_word;
      out_pc_q      <= pc_mem_q[rd_ptr_q];
      out_illegal_q <= dec_illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (load && dec_illegal && (TRAP_HOLD != 0)) state_d = TRAP;
        TRAP:    if (trap_clear) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_packed   = out_packed_q;
  assign out_pc       = out_pc_q;
  assign out_illegal  = out_illegal_q;
  assign trap_pending = (state_q == TRAP);
  assign occupancy    = count_q;

endmodule

// File: tb/tb_decode_stage_q.sv
// tb/tb_decode_stage_q.sv - randomized and directed bench for decode_stage_q against a queue-based reference model
module tb_decode_stage_q;

  localparam int D  = 4;
  localparam int OW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready, trap_clear;
  logic [31:0]   in_instr, in_pc;
  logic          in_ready, out_valid, out_illegal, trap_pending;
  logic [41:0]   out_packed;
  logic [31:0]   out_pc;
  logic [OW-1:0] occupancy;

  decode_stage_q #(.QUEUE_DEPTH(D), .TRAP_HOLD(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_packed(out_packed),
    .out_pc(out_pc), .out_illegal(out_illegal),
    .trap_pending(trap_pending), .trap_clear(trap_clear), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] mq[$];
  logic        mv, mill, mtrap;
  logic [31:0] mword, mpc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // {illegal, control word}
  function automatic logic [42:0] ref_decode(input logic [31:0] w);
    int opc, rs, rt, rd, fun, af, cad, pcm, gpm, sh;
    bit is_r, is_i, is_j, ill, gpwe, wr, rr;
    opc = int'(w[31:26]); rs = int'(w[25:21]); rt = int'(w[20:16]);
    rd = int'(w[15:11]); fun = int'(w[5:0]);
    is_i = opc == 35 || opc == 43 || (opc >= 8 && opc <= 15) || opc == 4 || opc == 5 ||
           (opc == 1 && rt < 2) || ((opc == 6 || opc == 7) && rt == 0);
    is_j = opc == 2 || opc == 3;
    is_r = (opc == 0 && ((fun >= 32 && fun <= 39) || fun == 2 || fun == 42 || fun == 43 ||
                         fun == 8 || fun == 10 || fun == 12)) ||
           (opc == 16 && ((rs == 16 && fun == 24) || rs == 4 || rs == 0));
    ill  = !(is_i || is_j || is_r);
    af   = is_r ? fun % 16 : ((w[28] == 1'b0 && w[27] == 1'b1) ? 8 : 0) + opc % 8;
    cad  = (opc == 3 || (opc == 0 && fun == 9)) ? 31 : (is_r ? rd : rt);
    gpwe = !ill && ((opc >= 8 && opc <= 15) || opc == 35 || opc == 3 || (opc == 0 && fun != 8));
    wr   = !ill && opc == 43;
    rr   = !ill && opc == 35;
    sh   = (is_r ? 0 : 4) + (af == 0 ? 0 : (af == 2 ? 1 : 2));
    pcm  = (opc == 0 && (fun == 8 || fun == 9)) ? 0 :
           ((opc >= 4 && opc <= 7) || opc == 1) ? 1 : (is_j ? 2 : 3);
    if (is_r)      gpm = (fun == 9) ? 3 : (fun == 2 || fun == 3) ? 2 : (opc == 16 && rs == 0) ? 4 : 0;
    else if (is_i) gpm = (opc == 35) ? 1 : (opc >= 8 && opc <= 15) ? 0 : 3;
    else           gpm = 3;
    return {ill, 4'(af), !is_r, !is_r, 3'(sh), 5'(cad), gpwe, 3'(gpm), w[28:26], w[16],
            2'(pcm), rs != 0, wr, rr, 5'(rs), 5'(rt), 5'(rd)};
  endfunction

  task automatic model_edge();
    logic full, ld, trap_old;
    logic [42:0] d;
    full     = (mq.size() == D);
    trap_old = mtrap;
    if (reset) begin
      mq.delete(); mv = 0; mill = 0; mtrap = 0; mword = 0; mpc = 0;
    end else if (flush) begin
      mq.delete(); mv = 0; mill = 0; mtrap = 0;
    end else begin
      ld = (mq.size() > 0) && !trap_old && (!mv || out_ready);
      if (ld) begin
        {mpc, mword} = mq.pop_front();
        d    = ref_decode(mword);
        mv   = 1;
        mill = d[42];
        if (mill) mtrap = 1;
      end else if (mv && out_ready) begin
        mv = 0;
      end
      if (trap_old && trap_clear) mtrap = 0;
      if (in_valid && !full) mq.push_back({in_pc, in_instr});
    end
  endtask

  task automatic compare();
    logic [42:0] d;
    chk("in_ready", in_ready, mq.size() != D);
    chk("occupancy", occupancy, mq.size());
    chk("out_valid", out_valid, mv);
    chk("trap_pending", trap_pending, mtrap);
    chk("out_illegal", out_illegal, mill);
    if (mv) begin
      d = ref_decode(mword);
      chk("out_packed", out_packed, d[41:0]);
      chk("out_pc", out_pc, mpc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_packed"}, out_packed, 0);
    chk({tag, "_pc"}, out_pc, 0);
    chk({tag, "_illegal"}, out_illegal, 0);
    chk({tag, "_trap"}, trap_pending, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    int f[13] = '{32, 33, 36, 39, 2, 3, 42, 43, 8, 9, 10, 12, 24};
    int s[4]  = '{16, 4, 0, 5};
    w = $urandom;
    case ($urandom_range(0, 9))
      0:    begin w[31:26] = 6'd0;  w[5:0] = 6'(f[$urandom_range(0, 12)]); end
      1:    begin w[31:26] = 6'd16; w[25:21] = 5'(s[$urandom_range(0, 3)]);
                  if ($urandom_range(0, 1) == 1) w[5:0] = 6'd24; end
      2:    w[31:26] = ($urandom_range(0, 1) == 1) ? 6'd35 : 6'd43;
      3:    w[31:26] = 6'(8 + $urandom_range(0, 7));
      4:    begin w[31:26] = 6'(4 + $urandom_range(0, 3));
                  if ($urandom_range(0, 1) == 1) w[20:16] = 5'd0; end
      5:    begin w[31:26] = 6'd1; w[20:16] = 5'($urandom_range(0, 3)); end
      6:    w[31:26] = 6'(2 + $urandom_range(0, 1));
      7:    ;
      default: w[31:26] = 6'd0;
    endcase
    return w;
  endfunction

  task automatic drive_push(input logic [31:0] w, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = w; in_pc = pc;
  endtask

  initial begin
    reset = 1; flush = 0; in_valid = 0; out_ready = 0; trap_clear = 0;
    in_instr = 0; in_pc = 0;
    mv = 0; mill = 0; mtrap = 0; mword = 0; mpc = 0;
    step(); step();
    check_reset("rst");
    reset = 0;

    // addi $1,$0,5
    out_ready = 1;
    drive_push(32'h20010005, 32'h100);
    step();
    in_valid = 0;
    step();
    chk("t1_valid", out_valid, 1);
    chk("t1_af", out_packed[41:38], 4'b0000);
    chk("t1_cad", out_packed[32:28], 5'd1);
    chk("t1_gp_we", out_packed[27], 1);
    chk("t1_gp_mux", out_packed[26:24], 3'b000);
    chk("t1_illegal", out_illegal, 0);

    // sw, lw, jal back to back
    drive_push(32'hAC220004, 32'h200); step();
    drive_push(32'h8C230008, 32'h204); step();
    chk("t2_sw_wren", out_packed[16], 1);
    chk("t2_sw_gp_we", out_packed[27], 0);
    drive_push(32'h0C000010, 32'h208); step();
    chk("t2_lw_rren", out_packed[15], 1);
    chk("t2_lw_gp_mux", out_packed[26:24], 3'b001);
    in_valid = 0; step();
    chk("t2_jal_cad", out_packed[32:28], 5'd31);
    chk("t2_jal_pcmux", out_packed[19:18], 2'b10);
    chk("t2_jal_pc", out_pc, 32'h208);

    // back-pressure: fill queue and output register
    step();
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      drive_push(32'h20010000 + i, 32'h300 + 4 * i);
      step();
    end
    chk("t3_full", in_ready, 0);
    chk("t3_occ", occupancy, D);
    in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t3_hold_pc", out_pc, 32'h300);
    chk("t3_hold_cad", out_packed[32:28], 5'd1);
    out_ready = 1;
    for (int i = 0; i < 6; i++) step();
    chk("t3_drained", occupancy, 0);

    // illegal word followed by addi, trap hold
    drive_push(32'hFC000000, 32'h400); step();
    drive_push(32'h20010005, 32'h404); step();
    chk("t4_illegal", out_illegal, 1);
    chk("t4_gp_we", out_packed[27], 0);
    chk("t4_trap", trap_pending, 1);
    in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_held", out_valid, 0);
    trap_clear = 1; step();
    trap_clear = 0;
    chk("t4_cleared", trap_pending, 0);
    step();
    chk("t4_issue_valid", out_valid, 1);
    chk("t4_issue_pc", out_pc, 32'h404);

    // flush with a same-cycle push
    step();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_push(gen_instr(), 32'h500 + 4 * i); step();
    end
    chk("t5_occ3", occupancy, 3);
    flush = 1; drive_push(32'h20010007, 32'h600); step();
    flush = 0; in_valid = 0;
    chk("t5_occ", occupancy, 0);
    chk("t5_valid", out_valid, 0);
    step();
    chk("t5_discard", occupancy, 0);

    // reset with a full queue
    for (int i = 0; i < 6; i++) begin
      drive_push(32'h20020000 + i, 32'h700 + 4 * i); step();
    end
    reset = 1; step();
    check_reset("t6");
    reset = 0; in_valid = 0;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_instr   = gen_instr();
      in_pc      = $urandom;
      out_ready  = ($urandom_range(0, 9) < 7);
      trap_clear = ($urandom_range(0, 99) < 15);
      flush      = ($urandom_range(0, 99) < 2);
      reset      = ($urandom_range(0, 999) < 5);
      step();
    end
    reset = 0; flush = 0; in_valid = 0; trap_clear = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
